// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux: registered one-hot grant, mux select
// and a tenure limit so a holder cannot starve the other side under contention.
module mux2to1_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       switched
);

  // state | meaning
  // IDLE  | no owner, gnt=00, sel holds its last value
  // OWN0  | requester 0 owns the mux, gnt=01, sel=0
  // OWN1  | requester 1 owns the mux, gnt=10, sel=1
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last, last_nxt;
  logic             switched_nxt;
  logic [1:0]       gnt_nxt;
  logic             sel_nxt;
  logic             busy_nxt;

  logic             cur_idx;
  logic             mine;
  logic             other;
  state_t           other_state;

  assign cur_idx     = (state == OWN1);
  assign mine        = req[cur_idx];
  assign other       = req[~cur_idx];
  assign other_state = cur_idx ? OWN0 : OWN1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      gnt      <= 2'b00;
      sel      <= 1'b0;
      busy     <= 1'b0;
      switched <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      switched <= switched_nxt;
    end
  end

  // Release has priority over the tenure limit; cnt only advances under contention.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_nxt     = last;
    switched_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        case (req)
          2'b01:   state_nxt = OWN0;
          2'b10:   state_nxt = OWN1;
          2'b11:   state_nxt = last ? OWN0 : OWN1;
          default: state_nxt = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        if (!mine) begin
          last_nxt = cur_idx;
          cnt_nxt  = '0;
          if (other) begin
            state_nxt    = other_state;
            switched_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (other) begin
          if (cnt == CNT_LAST) begin
            last_nxt     = cur_idx;
            cnt_nxt      = '0;
            state_nxt    = other_state;
            switched_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state; sel holds through IDLE.
  always_comb begin
    gnt_nxt  = 2'b00;
    sel_nxt  = sel;
    busy_nxt = 1'b0;
    case (state_nxt)
      OWN0: begin
        gnt_nxt  = 2'b01;
        sel_nxt  = 1'b0;
        busy_nxt = 1'b1;
      end
      OWN1: begin
        gnt_nxt  = 2'b10;
        sel_nxt  = 1'b1;
        busy_nxt = 1'b1;
      end
      default: begin
        gnt_nxt  = 2'b00;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD=8 and MAX_HOLD=1) share one req stream;
// a reference model pushes expected outputs, a monitor pops and compares each cycle.
module tb_mux2to1_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt0, gnt1;
  logic       sel0, sel1;
  logic       busy0, busy1;
  logic       sw0, sw1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [1:0] g0;
    logic       s0;
    logic       w0;
    logic [1:0] g1;
    logic       s1;
    logic       w1;
  } exp_t;

  exp_t q[$];

  localparam int HOLD [2] = '{8, 1};
  int   m_owner [2];
  int   m_cnt   [2];
  int   m_last  [2];
  logic m_sel   [2];

  mux2to1_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt0), .sel(sel0), .busy(busy0), .switched(sw0)
  );

  mux2to1_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .switched(sw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_cnt[m]   = 0;
      m_last[m]  = 1;
      m_sel[m]   = 1'b0;
    end
  endfunction

  // Ownership rules: idle ties go to the side that was not last served, a release
  // hands over directly, and HOLD contention cycles force the other side in.
  function automatic void model_step(input int m, input logic [1:0] r,
                                     output logic [1:0] g, output logic s, output logic sw);
    int i, j;
    sw = 1'b0;
    if (m_owner[m] < 0) begin
      if (r == 2'b01)      m_owner[m] = 0;
      else if (r == 2'b10) m_owner[m] = 1;
      else if (r == 2'b11) m_owner[m] = 1 - m_last[m];
      m_cnt[m] = 0;
    end else begin
      i = m_owner[m];
      j = 1 - i;
      if (!r[i]) begin
        m_last[m]  = i;
        m_cnt[m]   = 0;
        m_owner[m] = r[j] ? j : -1;
        sw         = r[j];
      end else if (r[j]) begin
        if (m_cnt[m] + 1 >= HOLD[m]) begin
          m_last[m]  = i;
          m_owner[m] = j;
          m_cnt[m]   = 0;
          sw         = 1'b1;
        end else begin
          m_cnt[m]++;
        end
      end
    end
    if (m_owner[m] >= 0) m_sel[m] = (m_owner[m] == 1);
    g = (m_owner[m] == 0) ? 2'b01 : (m_owner[m] == 1) ? 2'b10 : 2'b00;
    s = m_sel[m];
  endfunction

  task automatic drive(input logic [1:0] r, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req = r;
      model_step(0, r, e.g0, e.s0, e.w0);
      model_step(1, r, e.g1, e.s1, e.w1);
      q.push_back(e);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_gnt0",  int'(gnt0),  0);
    check("async_rst_sel0",  int'(sel0),  0);
    check("async_rst_busy0", int'(busy0), 0);
    check("async_rst_sw0",   int'(sw0),   0);
    check("async_rst_gnt1",  int'(gnt1),  0);
    check("async_rst_sel1",  int'(sel1),  0);
    model_reset();
    @(negedge clk);
    req = 2'b00;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("gnt0",  int'(gnt0),  int'(e.g0));
        check("sel0",  int'(sel0),  int'(e.s0));
        check("sw0",   int'(sw0),   int'(e.w0));
        check("busy0", int'(busy0), int'(|e.g0));
        check("gnt1",  int'(gnt1),  int'(e.g1));
        check("sel1",  int'(sel1),  int'(e.s1));
        check("sw1",   int'(sw1),   int'(e.w1));
        check("busy1", int'(busy1), int'(|e.g1));
      end
    end
  end

  initial begin : stimulus
    logic [1:0] r;
    rst = 1'b1;
    req = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt0",  int'(gnt0),  0);
    check("reset_sel0",  int'(sel0),  0);
    check("reset_busy0", int'(busy0), 0);
    @(negedge clk);
    rst = 1'b0;

    // single requester, then release: sel stays 0
    drive(2'b01, 3);
    drive(2'b00, 2);
    // OWN1 with five contention cycles, then async reset mid-tenure
    drive(2'b10, 1);
    drive(2'b11, 5);
    async_reset();
    // tie from reset: 8 cycles each side
    drive(2'b11, 20);
    drive(2'b00, 2);
    // handoff: requester 0 owns, 1 waits, 0 releases after three contention cycles
    async_reset();
    drive(2'b11, 4);
    drive(2'b10, 3);
    drive(2'b00, 2);
    // long uncontended tenure, then contention
    drive(2'b01, 20);
    drive(2'b11, 12);
    drive(2'b00, 2);
    // simultaneous release of both sides
    drive(2'b11, 3);
    drive(2'b00, 2);

    r = 2'b00;
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        async_reset();
        r = 2'b00;
      end
      r = r ^ {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
      drive(r, 1);
    end
    drive(2'b00, 2);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
